// File: rtl/addern_seq.sv
// addern_seq: multi-cycle N-bit adder/subtractor, C bits per clock.
// Start/Busy/Done handshake. Sum, Cout and Overflow are updated together
// when an operation completes and hold their values in between.
// Optional feature macro: ADDERN_SEQ_ACCUM_EN adds an Acc input. When a
// Start is accepted with Acc=1, the current Sum is used as operand A.
module addern_seq #(
  parameter int N = 8,
  parameter int C = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Sub,
  input  logic         Cin,
`ifdef ADDERN_SEQ_ACCUM_EN
  input  logic         Acc,
`endif
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Overflow,
  output logic         Busy,
  output logic         Done
);

  localparam int K  = N / C;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if (N < 2 || C < 1 || C > N || (N % C) != 0) begin : g_bad_params
    $error("addern_seq: N must be >= 2 and a multiple of C, with 1 <= C <= N");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_res;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;

  logic            w_accept;
  logic            w_last;
  int              w_base;
  logic [C-1:0]    w_a_chunk;
  logic [C-1:0]    w_b_chunk;
  logic [C:0]      w_sum;
  logic            w_cmsb;
  logic [N-1:0]    w_res_next;
  logic [N-1:0]    w_opa;

  // Start is accepted whenever no operation is in flight.
  assign w_accept = Start && (r_state != S_RUN);
  assign w_last   = (r_cnt == CW'(K - 1));

`ifdef ADDERN_SEQ_ACCUM_EN
  assign w_opa = Acc ? Sum : A;
`else
  assign w_opa = A;
`endif

  // Chunk adder: slice k of both operand registers plus the running carry.
  // The carry into the top bit of the chunk is recovered from the sum bit,
  // so it needs no separate low-part adder; on the last chunk it is the
  // carry into bit N-1 used for signed overflow.
  always_comb begin
    w_base     = int'(r_cnt) * C;
    w_a_chunk  = r_a[w_base +: C];
    w_b_chunk  = r_b[w_base +: C];
    w_sum      = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{C{1'b0}}, r_carry};
    w_cmsb     = w_sum[C-1] ^ w_a_chunk[C-1] ^ w_b_chunk[C-1];
    w_res_next = r_res;
    w_res_next[w_base +: C] = w_sum[C-1:0];
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (Start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = Start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register, operand capture, per-chunk datapath and output registers.
  // Sum takes the result register with the final chunk merged in, so the
  // outputs update on the same edge that writes the last chunk.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      r_state <= w_next;
      Busy    <= (w_next == S_RUN);
      Done    <= (w_next == S_DONE);
      if (w_accept) begin
        r_a     <= w_opa;
        r_b     <= Sub ? ~B : B;
        r_carry <= Sub ? ~Cin : Cin;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_res   <= w_res_next;
        r_carry <= w_sum[C];
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          Sum      <= w_res_next;
          Cout     <= w_sum[C];
          Overflow <= w_cmsb ^ w_sum[C];
        end
      end
    end
  end

endmodule

// File: tb/tb_addern_seq.sv
// tb_addern_seq: table-driven and scoreboard-checked bench for addern_seq
// with N=8, C=4 (two chunks, Done three cycles after an accepted Start).
module tb_addern_seq;

  localparam int N = 8;
  localparam int C = 4;
  localparam int K = N / C;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Start;
  logic         Sub;
  logic         Cin;
`ifdef ADDERN_SEQ_ACCUM_EN
  logic         Acc;
`endif
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Sum;
  logic         Cout;
  logic         Overflow;
  logic         Busy;
  logic         Done;

  addern_seq #(.N(N), .C(C)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Sub      (Sub),
    .Cin      (Cin),
`ifdef ADDERN_SEQ_ACCUM_EN
    .Acc      (Acc),
`endif
    .A        (A),
    .B        (B),
    .Sum      (Sum),
    .Cout     (Cout),
    .Overflow (Overflow),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    string        name;
    logic         sub;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  res_t         sb[$];
  int           done_cyc[$];
  logic [N-1:0] prev_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  always @(posedge Clock) cyc <= cyc + 1;

  // Result monitor: every Done pulse pops one expected result.
  always @(negedge Clock) begin
    res_t e;
    if (!Reset) begin
      if (Busy && Done) begin
        n_tests++;
        n_fail++;
        $display("FAIL busy_done_overlap: Busy and Done both high (cycle %0d)", cyc);
      end
      if (Done) begin
        done_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: Done with no operation pending (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("sum",      32'(Sum),      32'(e.sum));
          chk("cout",     32'(Cout),     32'(e.cout));
          chk("overflow", 32'(Overflow), 32'(e.ovf));
        end
      end
    end
  end

  // One operation with handshake timing checks; returns in the Done cycle.
  task automatic run_op(input vec_t v);
    res_t e;
    Sub   = v.sub;
    Cin   = v.cin;
    A     = v.a;
    B     = v.b;
    Start = 1'b1;
    e.sum = v.esum; e.cout = v.ecout; e.ovf = v.eovf;
    sb.push_back(e);
    chk({v.name, "_busy_c0"}, 32'(Busy), 32'd0);
    tick();
    Start = 1'b0;
    A = ~v.a; B = ~v.b; Sub = ~v.sub; Cin = ~v.cin;
    for (int i = 1; i <= K; i++) begin
      chk({v.name, "_busy_run"}, 32'(Busy), 32'd1);
      chk({v.name, "_done_run"}, 32'(Done), 32'd0);
      chk({v.name, "_sum_hold"}, 32'(Sum),  32'(prev_sum));
      tick();
    end
    chk({v.name, "_done"},      32'(Done), 32'd1);
    chk({v.name, "_busy_done"}, 32'(Busy), 32'd0);
    prev_sum = v.esum;
  endtask

  vec_t vecs[9];

  initial begin
    int n0;
    int s0;
    vecs[0] = '{"add",      1'b0, 1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0};
    vecs[1] = '{"sovf",     1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{"carry",    1'b0, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{"sub",      1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{"sub_ovf",  1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{"sub_bin",  1'b1, 1'b1, 8'h10, 8'h05, 8'h0A, 1'b1, 1'b0};
    vecs[6] = '{"neg_ovf",  1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{"cin_only", 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[8] = '{"sub_wrap", 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};

    Reset = 1'b1; Start = 1'b0; Sub = 1'b0; Cin = 1'b0; A = '0; B = '0;
`ifdef ADDERN_SEQ_ACCUM_EN
    Acc = 1'b0;
`endif
    prev_sum = '0;
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk("rst_sum",  32'(Sum),      32'd0);
    chk("rst_cout", 32'(Cout),     32'd0);
    chk("rst_ovf",  32'(Overflow), 32'd0);
    chk("rst_busy", 32'(Busy),     32'd0);
    chk("rst_done", 32'(Done),     32'd0);

    // Vector table; each op after the first starts in the previous Done cycle.
    foreach (vecs[i]) run_op(vecs[i]);
    tick();

    // Start during RUN is ignored; exactly one Done with the original result.
    n0 = done_cyc.size();
    Sub = 1'b0; Cin = 1'b0; A = 8'h3C; B = 8'h0F; Start = 1'b1;
    sb.push_back('{8'h4B, 1'b0, 1'b0});
    tick();
    A = 8'hFF; B = 8'hFF; Sub = 1'b1; Cin = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("ign_busy_c2", 32'(Busy), 32'd1);
    tick();
    chk("ign_done_c3", 32'(Done), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("ign_done_count", 32'(done_cyc.size() - n0), 32'd1);

    // Reset during RUN aborts with no Done and clears all outputs.
    n0 = done_cyc.size();
    Sub = 1'b0; Cin = 1'b0; A = 8'h7F; B = 8'h01; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    sb.delete();
    Reset = 1'b1;
    Start = 1'b1;
    tick();
    chk("abort_sum",  32'(Sum),      32'd0);
    chk("abort_cout", 32'(Cout),     32'd0);
    chk("abort_ovf",  32'(Overflow), 32'd0);
    chk("abort_busy", 32'(Busy),     32'd0);
    chk("abort_done", 32'(Done),     32'd0);
    Reset = 1'b0;
    Start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("abort_no_done", 32'(done_cyc.size() - n0), 32'd0);
    prev_sum = '0;

    // Start held high: back-to-back ops, new B captured at each acceptance.
    n0 = done_cyc.size();
    s0 = cyc;
    Sub = 1'b0; Cin = 1'b0; A = 8'h10; B = 8'h01; Start = 1'b1;
    sb.push_back('{8'h11, 1'b0, 1'b0});
    sb.push_back('{8'h12, 1'b0, 1'b0});
    sb.push_back('{8'h13, 1'b0, 1'b0});
    tick(); tick(); tick();
    B = 8'h02;
    tick(); tick(); tick();
    B = 8'h03;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("b2b_done_count", 32'(done_cyc.size() - n0), 32'd3);
    if (done_cyc.size() - n0 == 3) begin
      chk("b2b_latency", 32'(done_cyc[n0] - s0),             32'(K + 1));
      chk("b2b_gap1",    32'(done_cyc[n0+1] - done_cyc[n0]),   32'(K + 1));
      chk("b2b_gap2",    32'(done_cyc[n0+2] - done_cyc[n0+1]), 32'(K + 1));
    end
    prev_sum = 8'h13;

`ifdef ADDERN_SEQ_ACCUM_EN
    // Accumulate from zero after reset; A port is ignored while Acc=1.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    prev_sum = '0;
    Acc = 1'b1;
    begin
      vec_t v;
      v = '{"acc1", 1'b0, 1'b0, 8'hA5, 8'h10, 8'h10, 1'b0, 1'b0};
      run_op(v);
      tick();
      v = '{"acc2", 1'b0, 1'b0, 8'hA5, 8'h10, 8'h20, 1'b0, 1'b0};
      run_op(v);
      tick();
      v = '{"acc3", 1'b0, 1'b0, 8'hA5, 8'h10, 8'h30, 1'b0, 1'b0};
      run_op(v);
      tick();
    end
    Acc = 1'b0;
`endif

    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
